c_seq_gen_control: RTL and testbench
====================================

Name:
c_seq_gen_control

Overview:
- Controlled generator of the 3GPP TS 38.211 §5.2.1 length-31 Gold pseudo-random sequence c(n).
- On a start command it loads c_init and fast-forwards past Nc=1600 warm-up bits.
- It then skips a programmable offset and streams nGenBit bits per word under a show-ahead get handshake.
- Feeds PUCCH/DMRS scramblers and cyclic-shift (n_cs) calculators.

Parameters:
- nGenBit, 2, sequence bits delivered per output word (1..32).
- WARMUP_STEP, 32, bits advanced per cycle during warm-up; must divide NC.
- NC, 1600, warm-up length in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- i_start  in  1  one-cycle pulse; samples i_init/i_threshold and (re)starts generation.
- i_get  in  1  consume current word; ignored while o_valid=0.
- i_init  in  31  c_init, loaded into x2; x1 is initialised to 1 (x1[0]=1, others 0).
- i_threshold  in  16  offset in words skipped after warm-up.
- o_gen_bit  out  nGenBit  current word; bit k = c(n+k), LSB is earliest.
- o_valid  out  1  o_gen_bit holds a valid word.
- o_gen_done  out  1  one-cycle pulse when the first word becomes valid.

Behaviour:
- Reset (rst=0): state IDLE; x1, x2, counters, o_gen_bit, o_valid and o_gen_done all 0.
- Recurrences:
  - x1(n+31) = x1(n+3) ^ x1(n)
  - x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n)
  - c(n) = x1(n+Nc) ^ x2(n+Nc)
  - Multi-bit advances are combinational unrollings of these recurrences; no lookup tables.
- IDLE: wait for i_start.
- WARMUP:
  - Entered on i_start: x1 and x2 are loaded and a counter is cleared.
  - Advances WARMUP_STEP bits per cycle for NC/WARMUP_STEP cycles (50 by default).
- SKIP:
  - Advances nGenBit bits per cycle for i_threshold cycles.
  - Bypassed when i_threshold=0.
- READY:
  - o_gen_bit = c(m..m+nGenBit-1) for the current word index m, with o_valid=1.
  - On the entry cycle o_gen_done=1 for exactly one cycle.
- Latency from the i_start edge to o_valid=1: NC/WARMUP_STEP + i_threshold + 1 cycles.
- Get handshake (show-ahead):
  - If o_valid && i_get at a rising edge, the next word appears on the following cycle and o_valid stays 1.
  - Back-to-back gets stream one word per cycle.
  - With i_get low the word holds.
- No end of sequence: READY persists until the next i_start or reset. The word index wraps freely.
- i_start in any state, including mid-WARMUP or mid-READY:
  - Aborts the current run, reloads from the new inputs and returns to WARMUP.
  - o_valid drops on the next cycle.
- i_start has priority over a simultaneous i_get; that i_get is discarded.
- i_init and i_threshold are sampled only at i_start; later changes have no effect on the current run.
- An asynchronous rst assertion mid-run returns the block to IDLE immediately.

Optional Feature:
- Macro C_SEQ_GET_COUNT_EN.
- When defined:
  - Adds output port o_get_count[15:0], counting accepted gets since the last i_start.
  - The count clears on i_start and on reset, and wraps at 65535→0.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold rst=0 for 3 cycles, then release → o_valid=0, o_gen_done=0, o_gen_bit=0, no activity without i_start.
- Basic stream:
  - Stimulus: i_init={16'd56789,5'd0,10'd512}, i_threshold=0, i_start, hold i_get for 100 cycles.
  - Latency: o_valid rises 51 cycles after start, with a single o_gen_done pulse.
  - Data: 100 successive 2-bit words equal c(0..199) from a bit-serial golden model.
- Offset: i_init=512, i_threshold=42 → first word = c(84..85); latency 93 cycles.
- Pause/resume: after o_valid, i_get for 2 cycles, low for 10, high for 2 → words c(0..7) in order, held value stable while i_get=0.
- Restart: i_start issued mid-stream with a new i_init → o_valid drops next cycle, returns after 51 cycles with c(0) of the new seed; a simultaneous i_get has no effect.
- Feature on: with C_SEQ_GET_COUNT_EN defined, 100 gets → o_get_count=100; after i_start it reads 0.

Source files
------------

// File: rtl/c_seq_gen_control.sv
// Controlled length-31 Gold sequence generator: seed, warm-up, skip, show-ahead words.
// Optional macro C_SEQ_GET_COUNT_EN adds o_get_count (accepted gets since start).
module c_seq_gen_control #(
  parameter int nGenBit     = 2,
  parameter int WARMUP_STEP = 32,
  parameter int NC          = 1600
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_get,
  input  logic [30:0]        i_init,
  input  logic [15:0]        i_threshold,
  output logic [nGenBit-1:0] o_gen_bit,
  output logic               o_valid,
  output logic               o_gen_done
`ifdef C_SEQ_GET_COUNT_EN
  ,
  output logic [15:0]        o_get_count
`endif
);

  localparam logic [15:0] WARM_LAST = 16'(NC / WARMUP_STEP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARM,
    S_SKIP,
    S_FILL,
    S_READY
  } state_t;

  state_t state_q, state_d;

  logic [30:0]        x1_q, x1_d;
  logic [30:0]        x2_q, x2_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        thr_q, thr_d;
  logic [nGenBit-1:0] word_q, word_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic [30:0]        wx1, wx2;
  logic [30:0]        gx1, gx2;
  logic [nGenBit-1:0] gword;

  function automatic logic [30:0] nx1(input logic [30:0] x);
    return {x[3] ^ x[0], x[30:1]};
  endfunction

  function automatic logic [30:0] nx2(input logic [30:0] x);
    return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
  endfunction

  // Bit i of each register holds x(n+i); one step shifts in x(n+31).
  always_comb begin : warm_adv
    logic [30:0] a1;
    logic [30:0] a2;
    a1 = x1_q;
    a2 = x2_q;
    for (int i = 0; i < WARMUP_STEP; i++) begin
      a1 = nx1(a1);
      a2 = nx2(a2);
    end
    wx1 = a1;
    wx2 = a2;
  end

  always_comb begin : gen_adv
    logic [30:0] a1;
    logic [30:0] a2;
    a1    = x1_q;
    a2    = x2_q;
    gword = '0;
    for (int k = 0; k < nGenBit; k++) begin
      gword[k] = a1[0] ^ a2[0];
      a1 = nx1(a1);
      a2 = nx2(a2);
    end
    gx1 = a1;
    gx2 = a2;
  end

  always_comb begin
    state_d = state_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    word_d  = word_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (i_start) begin
      state_d = S_WARM;
      x1_d    = 31'd1;
      x2_d    = i_init;
      cnt_d   = '0;
      thr_d   = i_threshold;
      word_d  = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_WARM: begin
          x1_d  = wx1;
          x2_d  = wx2;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == WARM_LAST) begin
            cnt_d   = '0;
            state_d = (thr_q == 16'd0) ? S_FILL : S_SKIP;
          end
        end
        S_SKIP: begin
          x1_d  = gx1;
          x2_d  = gx2;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == thr_q - 16'd1) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end
        end
        // Prefetch the first word so it is shown ahead of any get.
        S_FILL: begin
          word_d  = gword;
          x1_d    = gx1;
          x2_d    = gx2;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_READY;
        end
        S_READY: begin
          if (i_get) begin
            word_d = gword;
            x1_d   = gx1;
            x2_d   = gx2;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x1_q    <= '0;
      x2_q    <= '0;
      cnt_q   <= '0;
      thr_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign o_gen_bit  = word_q;
  assign o_valid    = valid_q;
  assign o_gen_done = done_q;

`ifdef C_SEQ_GET_COUNT_EN
  logic [15:0] gcnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcnt_q <= '0;
    end else if (i_start) begin
      gcnt_q <= '0;
    end else if (valid_q && i_get) begin
      gcnt_q <= gcnt_q + 16'd1;
    end
  end

  assign o_get_count = gcnt_q;
`endif

endmodule

// File: tb/tb_c_seq_gen_control.sv
// Directed bench for c_seq_gen_control: latency table, streaming, pause, restart.
// Expected data comes from a bit-array model of the x1/x2 recurrences.
module tb_c_seq_gen_control;

  localparam logic [30:0] SEED_A = {16'd56789, 5'd0, 10'd512};
  localparam logic [30:0] SEED_B = 31'h2A5F_1C37;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_get = 1'b0;
  logic [30:0] i_init = '0;
  logic [15:0] i_threshold = '0;
  logic [1:0]  o_gen_bit;
  logic        o_valid;
  logic        o_gen_done;
`ifdef C_SEQ_GET_COUNT_EN
  logic [15:0] o_get_count;
`endif

  c_seq_gen_control dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_get      (i_get),
    .i_init     (i_init),
    .i_threshold(i_threshold),
    .o_gen_bit  (o_gen_bit),
    .o_valid    (o_valid),
    .o_gen_done (o_gen_done)
`ifdef C_SEQ_GET_COUNT_EN
    ,
    .o_get_count(o_get_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic cbuf [0:511];

  typedef struct {
    logic [30:0] init;
    logic [15:0] thr;
    int          lat;
    logic [31:0] w;
  } vec_t;

  vec_t tv [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic build(input logic [30:0] init);
    logic x1 [0:2199];
    logic x2 [0:2199];
    for (int i = 0; i < 31; i++) begin
      x1[i] = (i == 0);
      x2[i] = init[i];
    end
    for (int n = 0; n + 31 < 2200; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    for (int n = 0; n < 512; n++) cbuf[n] = x1[n+1600] ^ x2[n+1600];
  endtask

  function automatic logic [31:0] wexp(input int m);
    return {30'd0, cbuf[2*m+1], cbuf[2*m]};
  endfunction

  task automatic start_run(input logic [30:0] init, input logic [15:0] thr,
                           output int lat, output int dones);
    @(negedge clk);
    i_start     = 1'b1;
    i_init      = init;
    i_threshold = thr;
    @(posedge clk);
    @(negedge clk);
    i_start     = 1'b0;
    i_get       = 1'b0;
    i_init      = ~init;
    i_threshold = thr + 16'd5;
    chk("valid_drop", 32'(o_valid), 32'd0);
    lat   = 0;
    dones = 0;
    while (!o_valid && lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      dones += int'(o_gen_done);
    end
  endtask

  initial begin
    int lat;
    int dones;
    int m;
    logic pat [14];

    tv[0] = '{init: SEED_A, thr: 16'd0,  lat: 51, w: 32'd0};
    tv[1] = '{init: 31'd512, thr: 16'd42, lat: 93, w: 32'd0};
    tv[2] = '{init: SEED_B, thr: 16'd3,  lat: 54, w: 32'd0};
    tv[3] = '{init: 31'd1,   thr: 16'd1,  lat: 52, w: 32'd0};
    tv[4] = '{init: 31'd512, thr: 16'd0,  lat: 51, w: 32'd0};
    for (int i = 0; i < 5; i++) begin
      build(tv[i].init);
      tv[i].w = wexp(int'(tv[i].thr));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_done", 32'(o_gen_done), 32'd0);
    chk("rst_bits", 32'(o_gen_bit), 32'd0);
    repeat (60) @(negedge clk);
    chk("idle_valid", 32'(o_valid), 32'd0);

    for (int i = 0; i < 5; i++) begin
      start_run(tv[i].init, tv[i].thr, lat, dones);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("v%0d_done_cnt", i), 32'(dones), 32'd1);
      chk($sformatf("v%0d_word", i), 32'(o_gen_bit), tv[i].w);
      @(negedge clk);
      chk($sformatf("v%0d_done_off", i), 32'(o_gen_done), 32'd0);
      chk($sformatf("v%0d_hold", i), 32'(o_gen_bit), tv[i].w);
    end

    build(SEED_A);
    start_run(SEED_A, 16'd0, lat, dones);
    chk("stream_latency", 32'(lat), 32'd51);
    for (int k = 0; k < 100; k++) begin
      chk($sformatf("stream_w%0d", k), 32'(o_gen_bit), wexp(k));
      chk($sformatf("stream_v%0d", k), 32'(o_valid), 32'd1);
      i_get = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    i_get = 1'b0;
    chk("stream_w100", 32'(o_gen_bit), wexp(100));
`ifdef C_SEQ_GET_COUNT_EN
    chk("get_count_100", 32'(o_get_count), 32'd100);
`endif

    for (int k = 0; k < 14; k++) pat[k] = (k < 2) || (k >= 12);
    start_run(SEED_A, 16'd0, lat, dones);
    m = 0;
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("pause_c%0d", k), 32'(o_gen_bit), wexp(m));
      i_get = pat[k];
      @(posedge clk);
      @(negedge clk);
      if (pat[k]) m++;
    end
    i_get = 1'b0;
    chk("pause_end", 32'(o_gen_bit), wexp(4));

    i_get = 1'b1;
    repeat (5) @(negedge clk);
    build(SEED_B);
    start_run(SEED_B, 16'd0, lat, dones);
    chk("restart_latency", 32'(lat), 32'd51);
    chk("restart_done", 32'(dones), 32'd1);
    chk("restart_word", 32'(o_gen_bit), wexp(0));
`ifdef C_SEQ_GET_COUNT_EN
    chk("get_count_clr", 32'(o_get_count), 32'd0);
`endif
    i_get = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_get = 1'b0;
    chk("restart_next", 32'(o_gen_bit), wexp(1));

    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'd0);
    chk("async_rst_bits", 32'(o_gen_bit), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_idle", 32'(o_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
